// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction memory with program loader.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_e;

  localparam int NOP_WORD_DEFAULT = 0;

  // Even parity over a zero-extended word; callers pass up to 64 bits.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Load stream and fetch port of the instruction memory, grouped as one bus.
interface instr_mem_loader_if #(
  parameter int DATA_W = 17,
  parameter int ADDR_W = 8
);

  logic              load_start;
  logic [ADDR_W:0]   load_len;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              load_done;
  logic [ADDR_W:0]   loaded_count;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              fetch_oob;
  logic              par_err;

  modport master (
    output load_start, load_len, load_valid, load_data, fetch_req, fetch_addr,
    input  load_ready, load_done, loaded_count, fetch_ready, instr, instr_valid,
           fetch_oob, par_err
  );

  modport slave (
    input  load_start, load_len, load_valid, load_data, fetch_req, fetch_addr,
    output load_ready, load_done, loaded_count, fetch_ready, instr, instr_valid,
           fetch_oob, par_err
  );

endinterface

// File: rtl/imem_ram.sv
// Synchronous single-port RAM with one write port and a registered read port.
module imem_ram #(
  parameter int WIDTH  = 17,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // The array itself is never reset, so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else if (re_i) rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory with streaming program loader and registered fetch port.
// Defining IMEM_PARITY_EN stores an even-parity bit per word and checks it on fetch.
module instr_mem_loader
  import imem_pkg::*;
#(
  parameter int                DATA_W   = 17,
  parameter int                ADDR_W   = 8,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
  input logic               clk,
  input logic               rst,
  instr_mem_loader_if.slave bus
);

`ifdef IMEM_PARITY_EN
  localparam int RAM_W = DATA_W + 1;
`else
  localparam int RAM_W = DATA_W;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic              done_q, done_d;
  logic              valid_q, oob_q, hold_oob_q;
  logic              start_ok, wr_en, fetch_acc, fetch_in_range;
  logic [RAM_W-1:0]  ram_wdata, ram_rdata;

  assign start_ok       = bus.load_start && (bus.load_len != '0);
  assign bus.load_ready = (state_q == LOAD) && (count_q < len_q);
  assign wr_en          = bus.load_valid && bus.load_ready;
  assign bus.fetch_ready = (state_q == RUN);
  assign fetch_acc      = bus.fetch_req && bus.fetch_ready;
  assign fetch_in_range = {1'b0, bus.fetch_addr} < count_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    wptr_d  = wptr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, RUN: begin
        if (start_ok) begin
          state_d = LOAD;
          len_d   = bus.load_len;
          count_d = '0;
          wptr_d  = '0;
        end
      end
      LOAD: begin
        if (wr_en) begin
          count_d = count_q + 1'b1;
          wptr_d  = wptr_q + 1'b1;
          if ((count_q + 1'b1) == len_q) begin
            state_d = RUN;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // hold_oob_q only changes on an accepted fetch so instr keeps its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      oob_q      <= 1'b0;
      hold_oob_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      done_q  <= done_d;
      valid_q <= fetch_acc;
      oob_q   <= fetch_acc && !fetch_in_range;
      if (fetch_acc) hold_oob_q <= !fetch_in_range;
    end
  end

`ifdef IMEM_PARITY_EN
  assign ram_wdata   = {even_parity(64'(bus.load_data)), bus.load_data};
  assign bus.par_err = valid_q && !hold_oob_q && (^ram_rdata);
`else
  assign ram_wdata   = bus.load_data;
  assign bus.par_err = 1'b0;
`endif

  imem_ram #(
    .WIDTH (RAM_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .we_i   (wr_en),
    .re_i   (fetch_acc && fetch_in_range),
    .addr_i (wr_en ? wptr_q : bus.fetch_addr),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  assign bus.instr        = hold_oob_q ? NOP_WORD : ram_rdata[DATA_W-1:0];
  assign bus.instr_valid  = valid_q;
  assign bus.fetch_oob    = oob_q;
  assign bus.load_done    = done_q;
  assign bus.loaded_count = count_q;

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Parametrised instruction memory with a built-in program loader, the successor to the fixed 8-bit-address / 17-bit-word instruction memory. A streaming valid/ready port loads a program of a given length from address 0 upward. A registered fetch port then serves instruction reads with one-cycle latency and out-of-range detection. The block sits between the boot/host load path and the processor fetch stage.

## Interface
- DATA_W, 17, instruction word width
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words
- NOP_WORD, 0, value returned for out-of-range fetches (DATA_W bits)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- load_start  in  1  pulse; begin a program load
- load_len  in  ADDR_W+1  words to load, sampled with load_start; valid range 1..DEPTH
- load_valid  in  1  load word present
- load_data  in  DATA_W  load word
- load_ready  out  1  loader accepts a word
- load_done  out  1  one-cycle pulse after the last word is written
- loaded_count  out  ADDR_W+1  words currently valid in memory
- fetch_req  in  1  fetch request
- fetch_addr  in  ADDR_W  fetch address
- fetch_ready  out  1  fetch port available
- instr  out  DATA_W  fetched instruction
- instr_valid  out  1  instr is valid this cycle
- fetch_oob  out  1  qualifies instr_valid; fetch address was at or above loaded_count
- par_err  out  1  qualifies instr_valid; parity mismatch on the read word

## Operation
- FSM states: IDLE, LOAD, RUN.
- Transitions:
  - IDLE -> LOAD on load_start with load_len != 0.
  - LOAD -> RUN when the load_len-th word is accepted.
  - RUN -> LOAD on load_start with load_len != 0.
- load_start with load_len = 0 is ignored. load_start in LOAD is ignored.
- Entering LOAD: write pointer = 0 and loaded_count = 0.
- In LOAD:
  - load_ready = 1 while the pointer is below load_len.
  - Each accepted word (load_valid & load_ready) is written at the pointer; then the pointer and loaded_count increment.
- load_len = DEPTH: the pointer wraps to 0 after the final write, and no write occurs beyond DEPTH-1.
- fetch_ready = 1 only in RUN. fetch_req is ignored otherwise, with no response.
- Accepted fetch (fetch_req & fetch_ready):
  - fetch_addr < loaded_count: instr = mem[fetch_addr], fetch_oob = 0.
  - Otherwise: instr = NOP_WORD, fetch_oob = 1.
- Memory contents are not reset or cleared. Stale words above loaded_count are never returned.

## Timing
- Reset values:
  - state = IDLE, load_ready = 0, load_done = 0, loaded_count = 0.
  - fetch_ready = 0, instr = 0, instr_valid = 0, fetch_oob = 0, par_err = 0.
- load_ready rises the cycle after load_start is accepted. It falls the cycle after the last word is accepted.
- load_done pulses in the cycle after the last word is accepted. fetch_ready rises in that same cycle.
- Fetch latency:
  - A request accepted at edge N gives instr_valid = 1 for cycle N+1.
  - Back-to-back requests are served every cycle.
  - Without a new request, instr_valid = 0 and instr holds its last value.
- load_start and fetch_req in the same RUN cycle: the fetch is accepted and answered next cycle. fetch_ready = 0 from the next cycle on.
- rst mid-LOAD: IDLE and loaded_count = 0 next cycle. Partially written words become unreachable.
- rst takes priority over all inputs.

## Configuration
- IMEM_PARITY_EN defined:
  - Each word is stored as DATA_W+1 bits, with an even-parity bit computed on write.
  - The parity of the read word is checked on every in-range fetch.
  - On a mismatch, par_err = 1 alongside instr_valid.
- IMEM_PARITY_EN undefined:
  - Storage is DATA_W bits.
  - par_err remains a port, tied to 0.

## Structure
- Package imem_pkg holds:
  - the state enum (IDLE/LOAD/RUN);
  - NOP_WORD default;
  - a parity-function helper.
- Sub-module imem_ram:
  - synchronous single-port RAM, width DATA_W (+1 when parity is enabled), depth DEPTH;
  - one write port and one registered read port.
- instr_mem_loader holds the FSM, write pointer, loaded_count, the out-of-range comparison and output registers.

## Test plan
- Reset then idle: hold rst 3 cycles, then fetch_req = 1 at address 0x00 -> all outputs 0, fetch_ready = 0, no instr_valid.
- Basic load and fetch:
  - Load: load_start with load_len = 8, words 0x00000..0x00007, load_valid held high.
  - Expected: load_done 1 cycle after the 8th accept, loaded_count = 8.
  - Then fetch addresses 0..7 back-to-back -> instr = address, instr_valid the next cycle each.
- Out of range: after the 8-word load, fetch address 0x08 and 0xFF -> instr = NOP_WORD (0), fetch_oob = 1, instr_valid = 1.
- Full-depth load and backpressure:
  - load_len = 256, with load_valid toggled every other cycle.
  - Expected: 256 writes, loaded_count = 256, and a fetch of 0xFF returns the 256th word.
- Reset mid-load:
  - Assert rst after 3 of 8 words.
  - Expected: IDLE, loaded_count = 0.
  - Then reload with len = 2 and fetch 0x02 -> fetch_oob = 1.
- Parity (IMEM_PARITY_EN defined):
  - Force a bit flip in imem_ram at address 0x05.
  - Expected: fetching 0x05 gives par_err = 1. Fetching 0x04 gives par_err = 0.
